logic_unit_acc: RTL and testbench

- Parametrised bitwise logic unit for the datapath. Generalises the fixed-width OR gate family to WIDTH bits and four operations.
- Adds a registered valid/ready output and a multi-beat accumulate mode that folds a stream of operands into one result.
- Sits beside the ALU as the logic-op execution slot. Feeds the writeback stage through a ready/valid handshake.

---
 rtl/logic_unit_pkg.sv | 14 +
 rtl/logic_unit_acc_op.sv | 24 ++
 rtl/logic_unit_acc.sv | 123 ++++++++++++
 tb/tb_logic_unit_acc.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the logic-op execution slot.
package logic_unit_pkg;

  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NOR} op_e;
  typedef enum logic {S_IDLE, S_ACC} state_e;

  localparam int BEAT_CNT_W   = 8;
  localparam int BEAT_CNT_MAX = 255;

  function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] c);
    return (c == BEAT_CNT_W'(BEAT_CNT_MAX)) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/logic_unit_acc_op.sv
// Combinational bitwise operator z = op(x, y), one slice per bit.
module logic_op_bitwise
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  op_e              op,
  output logic [WIDTH-1:0] z
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    always_comb begin
      unique case (op)
        OP_AND:  z[i] = x[i] & y[i];
        OP_OR:   z[i] = x[i] | y[i];
        OP_XOR:  z[i] = x[i] ^ y[i];
        default: z[i] = ~(x[i] | y[i]);
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_acc.sv
// Bitwise logic unit with registered ready/valid output and multi-beat accumulate.
// Optional out_parity port when LOGIC_UNIT_PARITY_EN is defined.
module logic_unit_acc
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  acc_mode,
  input  logic                  last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_zero,
  output logic [BEAT_CNT_W-1:0] out_beats
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic                  out_parity
`endif
);

  state_e                  state_q, state_d;
  op_e                     op_q;
  logic [WIDTH-1:0]        acc_q;
  logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;

  logic                    accept, emit, load;
  logic [WIDTH-1:0]        opx, opy, res;
  op_e                     opsel;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Single operator instance: first beat uses (a,b,op), later beats fold a into acc with the latched op.
  always_comb begin
    opx   = a;
    opy   = b;
    opsel = op_e'(op);
    if (state_q == S_ACC) begin
      opx   = acc_q;
      opy   = a;
      opsel = op_q;
    end
  end

  logic_op_bitwise #(.WIDTH(WIDTH)) u_op (
    .x  (opx),
    .y  (opy),
    .op (opsel),
    .z  (res)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && acc_mode && !last) state_d = S_ACC;
      S_ACC:  if (accept && last)              state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load  = accept;
    emit  = 1'b0;
    cnt_d = sat_inc(cnt_q);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = BEAT_CNT_W'(1);
        emit  = accept && (!acc_mode || last);
      end
      S_ACC:   emit = accept && last;
      default: emit = 1'b0;
    endcase
  end

  // Accumulator and beat counter; harmless to load them on single-beat ops too.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      op_q  <= OP_AND;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= res;
      cnt_q <= cnt_d;
      if (state_q == S_IDLE) op_q <= op_e'(op);
    end
  end

  // Output register: emit only happens on an accepted beat, so it never overwrites a held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_zero   <= 1'b1;
      out_beats  <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_data   <= res;
      out_zero   <= (res == '0);
      out_beats  <= cnt_d;
`ifdef LOGIC_UNIT_PARITY_EN
      out_parity <= ^res;
`endif
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_acc.sv
// Randomized and directed bench for logic_unit_acc against a packet-level reference model.
module tb_logic_unit_acc;

  logic       clk, rst;
  logic       in_valid, in_ready, acc_mode, last, out_valid, out_ready, out_zero;
  logic [1:0] op;
  logic [7:0] a, b, out_data, out_beats;
`ifdef LOGIC_UNIT_PARITY_EN
  logic       out_parity;
`endif

  logic_unit_acc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .acc_mode(acc_mode), .last(last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero), .out_beats(out_beats)
`ifdef LOGIC_UNIT_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected output register and the open packet, if any.
  logic       m_valid;
  logic [7:0] m_data;
  int         m_beats;
  logic       in_pkt;
  logic [1:0] pkt_op;
  logic [7:0] pkt_acc;
  int         pkt_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] f(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_beats = 0; in_pkt = 0; pkt_op = 0; pkt_acc = 0; pkt_n = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_data"},  32'(out_data),  32'(m_data));
    chk({tag, "_zero"},  32'(out_zero),  32'(m_data == 8'h00));
    chk({tag, "_beats"}, 32'(out_beats), 32'(m_beats));
`ifdef LOGIC_UNIT_PARITY_EN
    chk({tag, "_par"},   32'(out_parity), 32'(^m_data));
`endif
  endtask

  // One clock: drive on negedge, check in_ready, advance the model at posedge, check outputs after.
  task automatic cyc(input logic iv, input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                     input logic am, input logic ls, input logic ordy, input logic r);
    logic       exp_rdy, emit;
    logic [7:0] r8;
    int         nb;
    @(negedge clk);
    in_valid = iv; op = o; a = aa; b = bb; acc_mode = am; last = ls; out_ready = ordy; rst = r;
    #1;
    exp_rdy = !m_valid || ordy;
    if (!r) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) model_reset();
    else begin
      emit = 0; r8 = 0; nb = 0;
      if (iv && exp_rdy) begin
        if (!in_pkt) begin
          r8 = f(o, aa, bb);
          if (!am || ls) begin emit = 1; nb = 1; end
          else begin in_pkt = 1; pkt_op = o; pkt_acc = r8; pkt_n = 1; end
        end else begin
          r8 = f(pkt_op, pkt_acc, aa);
          pkt_n++;
          if (ls) begin emit = 1; nb = (pkt_n > 255) ? 255 : pkt_n; in_pkt = 0; end
          else pkt_acc = r8;
        end
      end
      if (emit) begin m_valid = 1; m_data = r8; m_beats = nb; end
      else if (ordy) m_valid = 0;
    end
    #1;
    check_outputs("out");
  endtask

  task automatic idle(input logic ordy);
    cyc(0, 2'd0, 8'h00, 8'h00, 0, 0, ordy, 0);
  endtask

  initial begin
    model_reset();
    in_valid = 0; op = 0; a = 0; b = 0; acc_mode = 0; last = 0; out_ready = 1; rst = 1;
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_zero",  32'(out_zero),  32'd1);
    chk("rst_beats", 32'(out_beats), 32'd0);

    // Single OR
    cyc(1, 2'd1, 8'hA0, 8'h0F, 0, 0, 1, 0);
    chk("t1_data", 32'(out_data), 32'hAF);
    chk("t1_beats", 32'(out_beats), 32'd1);
    idle(1);

    // XOR accumulate, 3 beats
    cyc(1, 2'd2, 8'hFF, 8'h0F, 1, 0, 1, 0);
    chk("t2_novalid1", 32'(out_valid), 32'd0);
    cyc(1, 2'd0, 8'h33, 8'h00, 0, 0, 1, 0);
    chk("t2_novalid2", 32'(out_valid), 32'd0);
    cyc(1, 2'd3, 8'h01, 8'hAA, 0, 1, 1, 0);
    chk("t2_data", 32'(out_data), 32'hC2);
    chk("t2_beats", 32'(out_beats), 32'd3);
    idle(1);

    // Backpressure: hold result 4 cycles with a second beat queued, then drain
    cyc(1, 2'd1, 8'h11, 8'h22, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2'd0, 8'hF0, 8'h3C, 0, 0, 0, 0);
    chk("t3_held", 32'(out_data), 32'h33);
    cyc(1, 2'd0, 8'hF0, 8'h3C, 0, 0, 1, 0);
    chk("t3_second", 32'(out_data), 32'h30);
    idle(1);
    chk("t3_drained", 32'(out_valid), 32'd0);

    // Zero flag and parity
    cyc(1, 2'd0, 8'h0F, 8'hF0, 0, 0, 1, 0);
    chk("t4_zero", 32'(out_zero), 32'd1);
    cyc(1, 2'd0, 8'h01, 8'hFF, 0, 0, 1, 0);
    chk("t4_data", 32'(out_data), 32'h01);
    idle(1);

    // Reset mid-packet, then NOR
    cyc(1, 2'd1, 8'h01, 8'h02, 1, 0, 1, 0);
    cyc(1, 2'd1, 8'h04, 8'h00, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    idle(1);
    chk("t5_no_result", 32'(out_valid), 32'd0);
    cyc(1, 2'd3, 8'h00, 8'h00, 0, 0, 1, 0);
    chk("t5_nor", 32'(out_data), 32'hFF);
    chk("t5_beats", 32'(out_beats), 32'd1);
    idle(1);

    // Saturation: 300-beat OR packet
    cyc(1, 2'd1, 8'h01, 8'h00, 1, 0, 1, 0);
    for (int i = 1; i < 299; i++) cyc(1, 2'd2, 8'h01, 8'h55, 0, 0, 1, 0);
    cyc(1, 2'd2, 8'h01, 8'h55, 0, 1, 1, 0);
    chk("t6_data", 32'(out_data), 32'h01);
    chk("t6_beats", 32'(out_beats), 32'd255);
    idle(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
